// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall scheduler for a 5-stage RISC-V pipeline: load-use bubbles, branch flushes, dmem-wait freeze.
// Optional HAZARD_PERF_CNT_EN adds stall/flush perf counters; undefined ties them to zero.
module pipeline_hazard_ctrl #(
    parameter int REG_W             = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic [REG_W-1:0] if_id_rs1,
    input  logic [REG_W-1:0] if_id_rs2,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             id_ex_enable,
    output logic             id_ex_flush,
    output logic             ex_mem_enable,
    output logic             mem_timeout_err,
    output logic [1:0]       ctrl_state,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        ST_RSV     = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  stall_cnt;
    logic [15:0] wait_cnt;

    logic load_use;
    logic stall_mode;
    logic freeze;
    logic do_branch;
    logic do_bubble;

    assign load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                      ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

    // A wait that interrupted a load stall keeps its bubble count, so stall rules resume after ready.
    assign stall_mode = ((state == LOAD_STALL) || (state == MEM_WAIT)) && (stall_cnt != 4'd0);

    always_comb begin
        freeze    = 1'b0;
        do_branch = 1'b0;
        do_bubble = 1'b0;
        if (state == MEM_WAIT)
            freeze = !dmem_ready;
        else
            freeze = mem_access && !dmem_ready;
        if (!freeze) begin
            if (branch_taken)
                do_branch = 1'b1;
            else if (stall_mode || load_use)
                do_bubble = 1'b1;
        end
    end

    assign pc_enable     = reset && !freeze && !do_bubble;
    assign if_id_enable  = reset && !freeze && !do_bubble;
    assign if_id_flush   = reset && do_branch;
    assign id_ex_enable  = reset && !freeze;
    assign id_ex_flush   = reset && (do_branch || do_bubble);
    assign ex_mem_enable = reset && !freeze;
    assign ctrl_state    = state;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state           <= RUN;
            stall_cnt       <= 4'd0;
            wait_cnt        <= 16'd0;
            mem_timeout_err <= 1'b0;
        end else if (freeze) begin
            state <= MEM_WAIT;
            if (state != MEM_WAIT) begin
                wait_cnt <= 16'd1;
            end else begin
                if (wait_cnt == 16'(MEM_TIMEOUT))
                    mem_timeout_err <= 1'b1;
                if (wait_cnt != '1)
                    wait_cnt <= wait_cnt + 16'd1;
            end
        end else begin
            wait_cnt <= 16'd0;
            if (do_branch) begin
                stall_cnt <= 4'd0;
                state     <= RUN;
            end else if (stall_mode) begin
                stall_cnt <= stall_cnt - 4'd1;
                state     <= (stall_cnt == 4'd1) ? RUN : LOAD_STALL;
            end else if (load_use && (LOAD_STALL_CYCLES > 1)) begin
                stall_cnt <= 4'(LOAD_STALL_CYCLES - 1);
                state     <= LOAD_STALL;
            end else begin
                state <= RUN;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (!pc_enable)
                stall_q <= stall_q + 32'd1;
            if (if_id_flush)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl; two instances (1-bubble and 3-bubble)
// checked each cycle against a bubble/freeze accounting model.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int LSC_A = 1;
    localparam int MT_A  = 8;
    localparam int LSC_B = 3;
    localparam int MT_B  = 4;

    logic             clk = 1'b1;
    logic             reset = 1'b0;
    logic             ld = 1'b0;
    logic [REG_W-1:0] rd = '0;
    logic [REG_W-1:0] rs1 = '0;
    logic [REG_W-1:0] rs2 = '0;
    logic             br = 1'b0;
    logic             ma = 1'b0;
    logic             rdy = 1'b0;

    logic [1:0]  pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush, ex_mem_enable, mem_timeout_err;
    logic [1:0]  ctrl_state [2];
    logic [31:0] stall_cycles [2];
    logic [31:0] flush_count [2];

    int n_cmp = 0;
    int n_bad = 0;

    // model: bubbles still owed, whether the pipe is frozen on dmem, and how long it has waited
    int          lsc [2] = '{LSC_A, LSC_B};
    int          mt [2] = '{MT_A, MT_B};
    int          owed [2];
    bit          frozen [2];
    int          waited [2];
    bit          err [2];
    int unsigned stalls [2];
    int unsigned flushes [2];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(REG_W), .LOAD_STALL_CYCLES(LSC_A), .MEM_TIMEOUT(MT_A)) dut_a (
        .clk(clk), .reset(reset), .id_ex_mem_read(ld), .id_ex_rd(rd), .if_id_rs1(rs1), .if_id_rs2(rs2),
        .branch_taken(br), .mem_access(ma), .dmem_ready(rdy),
        .pc_enable(pc_enable[0]), .if_id_enable(if_id_enable[0]), .if_id_flush(if_id_flush[0]),
        .id_ex_enable(id_ex_enable[0]), .id_ex_flush(id_ex_flush[0]), .ex_mem_enable(ex_mem_enable[0]),
        .mem_timeout_err(mem_timeout_err[0]), .ctrl_state(ctrl_state[0]),
        .stall_cycles(stall_cycles[0]), .flush_count(flush_count[0])
    );

    pipeline_hazard_ctrl #(.REG_W(REG_W), .LOAD_STALL_CYCLES(LSC_B), .MEM_TIMEOUT(MT_B)) dut_b (
        .clk(clk), .reset(reset), .id_ex_mem_read(ld), .id_ex_rd(rd), .if_id_rs1(rs1), .if_id_rs2(rs2),
        .branch_taken(br), .mem_access(ma), .dmem_ready(rdy),
        .pc_enable(pc_enable[1]), .if_id_enable(if_id_enable[1]), .if_id_flush(if_id_flush[1]),
        .id_ex_enable(id_ex_enable[1]), .id_ex_flush(id_ex_flush[1]), .ex_mem_enable(ex_mem_enable[1]),
        .mem_timeout_err(mem_timeout_err[1]), .ctrl_state(ctrl_state[1]),
        .stall_cycles(stall_cycles[1]), .flush_count(flush_count[1])
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [8:0] ctl_vec(input int i);
        return {pc_enable[i], if_id_enable[i], if_id_flush[i], id_ex_enable[i], id_ex_flush[i],
                ex_mem_enable[i], mem_timeout_err[i], ctrl_state[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            owed[i] = 0; frozen[i] = 0; waited[i] = 0; err[i] = 0; stalls[i] = 0; flushes[i] = 0;
        end
    endtask

    task automatic check_counters(input int i);
`ifdef HAZARD_PERF_CNT_EN
        chk($sformatf("stall_cycles%0d", i), stall_cycles[i], stalls[i]);
        chk($sformatf("flush_count%0d", i), flush_count[i], flushes[i]);
`else
        chk($sformatf("stall_cycles%0d", i), stall_cycles[i], 0);
        chk($sformatf("flush_count%0d", i), flush_count[i], 0);
`endif
    endtask

    // one pipeline cycle: apply inputs after posedge, check before the negedge update
    task automatic cycle(input logic i_ma, input logic i_rdy, input logic i_br, input logic i_ld,
                         input int i_rd, input int i_rs1, input int i_rs2);
        bit hz;
        int kind;
        bit pc, iffl, ixen, ixfl;
        logic [1:0] st;
        @(posedge clk);
        ma = i_ma; rdy = i_rdy; br = i_br; ld = i_ld;
        rd = REG_W'(i_rd); rs1 = REG_W'(i_rs1); rs2 = REG_W'(i_rs2);
        #1;
        hz = i_ld && (i_rd != 0) && (i_rd == i_rs1 || i_rd == i_rs2);
        for (int i = 0; i < 2; i++) begin
            st = frozen[i] ? 2'd2 : (owed[i] > 0 ? 2'd1 : 2'd0);
            if (frozen[i] ? !i_rdy : (i_ma && !i_rdy)) kind = 1;      // freeze
            else if (i_br)                             kind = 2;      // flush wrong path
            else if (owed[i] > 0 || hz)                kind = 3;      // bubble
            else                                       kind = 0;
            pc   = (kind == 0 || kind == 2);
            iffl = (kind == 2);
            ixen = (kind != 1);
            ixfl = (kind >= 2);
            chk($sformatf("ctl%0d", i), ctl_vec(i), {pc, pc, iffl, ixen, ixfl, ixen, err[i], st});
            check_counters(i);
            if (kind == 1) begin
                if (frozen[i]) begin
                    if (waited[i] == mt[i]) err[i] = 1;
                    if (waited[i] < 65535) waited[i]++;
                end else begin
                    frozen[i] = 1;
                    waited[i] = 1;
                end
            end else begin
                frozen[i] = 0;
                waited[i] = 0;
                if (kind == 2) owed[i] = 0;
                else if (kind == 3) owed[i] = (owed[i] > 0) ? owed[i] - 1 : lsc[i] - 1;
            end
            if (!pc) stalls[i]++;
            if (kind == 2) flushes[i]++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 1, 0, 0, 0, 0, 0);
    endtask

    // async reset mid-cycle: outputs must drop immediately, not at the next edge
    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        ma = 0; rdy = 1; br = 0; ld = 0; rd = '0; rs1 = '0; rs2 = '0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ctl%0d", i), ctl_vec(i), 0);
            check_counters(i);
        end
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("init_ctl%0d", i), ctl_vec(i), 0);
            check_counters(i);
        end
        @(posedge clk);
        #2 reset = 1'b1;

        // reset while frozen on dmem
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        do_reset();
        idle(2);

        // load-use: rd=5 vs rs2=5, then rd=0 never hazards
        cycle(0, 1, 0, 1, 5, 1, 5);
        idle(4);
        cycle(0, 1, 0, 1, 0, 0, 0);
        idle(3);

        // load-use on rs1, then branch coincident with a load-use
        cycle(0, 1, 0, 1, 7, 7, 2);
        idle(4);
        cycle(0, 1, 1, 1, 3, 3, 3);
        idle(2);

        // branch aborts a multi-cycle stall
        cycle(0, 1, 0, 1, 4, 4, 0);
        cycle(0, 1, 1, 0, 0, 0, 0);
        idle(2);

        // four frozen cycles with a branch during the freeze, then resume
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 2, 2, 2);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 0, 0);
        idle(2);

        // dmem wait arriving mid load stall, stall resumes after ready
        cycle(0, 1, 0, 1, 6, 0, 6);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        idle(4);

        // timeout: ready held low past both limits, err sticky until reset
        for (int k = 0; k < 12; k++) cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        idle(3);
        do_reset();
        idle(2);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
